lsu_mem_ctrl: RTL and testbench
===============================

Name: lsu_mem_ctrl

Overview:
- Load/store initiator between the core's execute stage and the byte-masked, word-organised data memory.
- Turns core byte/half/word load and store requests into word-aligned memory accesses: byte-mask generation, write-data lane shifting, read-data extraction and sign/zero extension.
- A misaligned access that crosses a word boundary is split into two sequential word accesses.
- Handshake on the core side; drives the memory's address, write-data, byte-mask and write-enable inputs.

Parameters:
DEPTH, 2048, memory size in bytes; power of two, at least 8.
AW, $clog2(DEPTH), memory byte-address width; derived, do not override.

Ports:
i_clk  in  1  clock; all state updates on rising edge
i_rst_n  in  1  asynchronous active-low reset
i_req_valid  in  1  core request valid
o_req_ready  out  1  high only in IDLE; request accepted when valid&&ready at a rising edge
i_req_we  in  1  1 = store, 0 = load
i_req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
i_req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend
i_req_addr  in  32  byte address
i_req_wdata  in  32  store data, right-justified
o_rsp_valid  out  1  one-cycle response pulse
o_rsp_rdata  out  32  extended load data; 0 for stores and errors
o_rsp_err  out  1  valid with o_rsp_valid: out-of-range address or illegal size
o_mem_addr  out  AW  word-aligned byte address; bits [1:0] always 0
o_mem_wdata  out  32  lane-shifted write data
o_mem_bmask  out  4  byte-lane enable, relative to o_mem_addr
o_mem_wren  out  1  memory write enable
i_mem_rdata  in  32  memory read word; valid the cycle after o_mem_addr is presented (synchronous read)

Behaviour:
- Reset (async, i_rst_n=0): state IDLE; o_req_ready=1 after release; o_rsp_valid=0, o_rsp_err=0, o_rsp_rdata=0, o_mem_addr=0, o_mem_wdata=0, o_mem_bmask=0, o_mem_wren=0. Outputs clear immediately, not at the next edge.
- Accept: latch we/size/unsigned/addr/wdata. Define off=addr[1:0], n=1/2/4 from size, base mask=0001/0011/1111, cross=(off+n>4).
- Error at accept: size==11, or addr+n-1 >= DEPTH (computed 33-bit, no wrap). Go directly to RESP with err=1, rdata=0; no memory cycle issued (wren stays 0).
- FSM states IDLE, ACC1, ACC2, RESP:
  - IDLE -> ACC1 on accept (no error); IDLE -> RESP on accept with error.
  - ACC1: o_mem_addr={addr[AW-1:2],2'b00}; for stores wren=1, bmask=(base<<off)[3:0], wdata=wdata<<(8*off). For loads wren=0, bmask=0. ACC1 -> ACC2 if cross, else -> RESP.
  - ACC2: o_mem_addr = word address + 4; for stores wren=1, bmask=base>>(4-off), wdata=wdata>>(8*(4-off)). For loads, latch i_mem_rdata (word0) into lo_word. ACC2 -> RESP.
  - RESP: o_rsp_valid=1 for exactly one cycle. Load data = ({i_mem_rdata,lo_word}>>(8*off)) if cross, else i_mem_rdata>>(8*off). Take the low n bytes, then extend per size/unsigned. Stores return 0. RESP -> IDLE unconditionally; the core must consume the response in that cycle.
- Memory outputs are 0 in IDLE and RESP; o_mem_* change only on state transitions.
- Latency (accept edge to rsp cycle): aligned/non-crossing = 2 cycles; crossing = 3; error = 1.
- A request with valid held in any non-IDLE state is ignored (ready=0).
- Reset mid-operation: FSM aborts. A crossing store reset during ACC2 keeps its ACC1 half (committed at the previous edge); the ACC2 half is not written. No response is produced.

Test Plan:
1. SW addr=8 data=0x12345678 -> ACC1: mem_addr=8, bmask=1111, wren=1; rsp 2 cycles after accept, err=0. Then LW addr=8 -> rsp_rdata=0x12345678, 2-cycle latency.
2. SB addr=5 data=0xAABBCCDD -> mem_addr=4, bmask=0010, wdata=0xBBCCDD00. Then LB addr=5 -> 0xFFFFFFDD; LBU addr=5 -> 0x000000DD.
3. SW addr=6 data=0xCAFEBABE -> ACC1: addr=4, bmask=1100, wdata=0xBABE0000; ACC2: addr=8, bmask=0011, wdata=0x0000CAFE. Then LW addr=6 -> 0xCAFEBABE, 3-cycle latency.
4. SH addr=7 data=0x00008001 -> ACC1: addr=4, bmask=1000, wdata=0x01000000; ACC2: addr=8, bmask=0001, wdata=0x00000080. Then LH addr=7 -> 0xFFFF8001; LHU addr=7 -> 0x00008001.
5. DEPTH=32: LW addr=30 -> wren=0 throughout, rsp 1 cycle after accept, err=1, rdata=0. Size=11 at addr=0 -> same. LB addr=31 -> legal, err=0.
6. Reset asserted during ACC2 of SW addr=6 data=0xCAFEBABE, with memory pre-cleared -> wren=0 immediately, no rsp_valid. After release, ready=1; LW addr=4 -> 0xBABE0000 and LW addr=8 -> 0x00000000.

Source files
------------

// File: rtl/lsu_mem_ctrl.sv
// Load/store initiator: maps core byte/half/word requests onto a byte-masked,
// word-organised synchronous-read memory, splitting word-crossing accesses in two.
module lsu_mem_ctrl #(
    parameter  int DEPTH = 2048,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_req_valid,
    output logic          o_req_ready,
    input  logic          i_req_we,
    input  logic [1:0]    i_req_size,
    input  logic          i_req_unsigned,
    input  logic [31:0]   i_req_addr,
    input  logic [31:0]   i_req_wdata,
    output logic          o_rsp_valid,
    output logic [31:0]   o_rsp_rdata,
    output logic          o_rsp_err,
    output logic [AW-1:0] o_mem_addr,
    output logic [31:0]   o_mem_wdata,
    output logic [3:0]    o_mem_bmask,
    output logic          o_mem_wren,
    input  logic [31:0]   i_mem_rdata
);

    typedef enum logic [1:0] {IDLE, ACC1, ACC2, RESP} state_t;

    state_t      state;
    logic        we_q, uns_q, cross_q, err_q;
    logic [1:0]  size_q, off_q;
    logic [3:0]  hi_mask_q;
    logic [31:0] hi_wdata_q, lo_word;

    logic        accept;
    logic [1:0]  req_off;
    logic [2:0]  req_n;
    logic [3:0]  req_base;
    logic [7:0]  lane_mask;
    logic [63:0] lane_wdata;
    logic [32:0] req_last;
    logic        req_cross, req_err;
    logic [31:0] rd_word, rd_ext;

    assign o_req_ready = (state == IDLE);
    assign accept      = i_req_valid && o_req_ready;

    // Lane placement is done once over an 8-lane window: the low half feeds the
    // first word access, the high half is held for the second.
    // NOTE: every variable written here gets a value on every path, so no latch is inferred.
    always_comb begin
        req_off = i_req_addr[1:0];
        case (i_req_size)
            2'b00:   begin req_n = 3'd1; req_base = 4'b0001; end
            2'b01:   begin req_n = 3'd2; req_base = 4'b0011; end
            default: begin req_n = 3'd4; req_base = 4'b1111; end
        endcase
        lane_mask  = {4'd0, req_base} << req_off;
        lane_wdata = {32'd0, i_req_wdata} << {req_off, 3'b000};
        req_cross  = ({1'b0, req_n} + {2'b00, req_off}) > 4'd4;
        req_last   = {1'b0, i_req_addr} + {30'd0, req_n} - 33'd1;
        req_err    = (i_req_size == 2'b11) || (req_last >= 33'(DEPTH));
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            we_q        <= 1'b0;
            uns_q       <= 1'b0;
            cross_q     <= 1'b0;
            err_q       <= 1'b0;
            size_q      <= 2'b00;
            off_q       <= 2'b00;
            hi_mask_q   <= 4'b0;
            hi_wdata_q  <= '0;
            lo_word     <= '0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
            o_mem_bmask <= 4'b0;
            o_mem_wren  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    we_q       <= i_req_we;
                    uns_q      <= i_req_unsigned;
                    size_q     <= i_req_size;
                    off_q      <= req_off;
                    cross_q    <= req_cross;
                    err_q      <= req_err;
                    hi_mask_q  <= lane_mask[7:4];
                    hi_wdata_q <= lane_wdata[63:32];
                    if (req_err) begin
                        state <= RESP;
                    end else begin
                        state       <= ACC1;
                        o_mem_addr  <= {i_req_addr[AW-1:2], 2'b00};
                        o_mem_wren  <= i_req_we;
                        o_mem_bmask <= i_req_we ? lane_mask[3:0] : 4'b0;
                        o_mem_wdata <= i_req_we ? lane_wdata[31:0] : '0;
                    end
                end
                ACC1: begin
                    if (cross_q) begin
                        state       <= ACC2;
                        o_mem_addr  <= o_mem_addr + AW'(4);
                        o_mem_wren  <= we_q;
                        o_mem_bmask <= we_q ? hi_mask_q : 4'b0;
                        o_mem_wdata <= we_q ? hi_wdata_q : '0;
                    end else begin
                        state       <= RESP;
                        o_mem_addr  <= '0;
                        o_mem_wren  <= 1'b0;
                        o_mem_bmask <= 4'b0;
                        o_mem_wdata <= '0;
                    end
                end
                ACC2: begin
                    // Read data for the first word arrives during this cycle.
                    lo_word     <= i_mem_rdata;
                    state       <= RESP;
                    o_mem_addr  <= '0;
                    o_mem_wren  <= 1'b0;
                    o_mem_bmask <= 4'b0;
                    o_mem_wdata <= '0;
                end
                RESP: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        rd_word = cross_q ? 32'({i_mem_rdata, lo_word} >> {off_q, 3'b000})
                          : i_mem_rdata >> {off_q, 3'b000};
        case (size_q)
            2'b00:   rd_ext = {{24{rd_word[7]  & ~uns_q}}, rd_word[7:0]};
            2'b01:   rd_ext = {{16{rd_word[15] & ~uns_q}}, rd_word[15:0]};
            default: rd_ext = rd_word;
        endcase
    end

    assign o_rsp_valid = (state == RESP);
    assign o_rsp_err   = o_rsp_valid && err_q;
    assign o_rsp_rdata = (o_rsp_valid && !we_q && !err_q) ? rd_ext : 32'd0;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Scoreboard bench for lsu_mem_ctrl against a byte-masked synchronous-read memory model.
module tb_lsu_mem_ctrl;

    localparam int DEPTH = 32;
    localparam int AW    = $clog2(DEPTH);

    logic          i_clk = 1'b0;
    logic          i_rst_n = 1'b1;
    logic          i_req_valid = 1'b0;
    logic          o_req_ready;
    logic          i_req_we = 1'b0;
    logic [1:0]    i_req_size = 2'b00;
    logic          i_req_unsigned = 1'b0;
    logic [31:0]   i_req_addr = '0;
    logic [31:0]   i_req_wdata = '0;
    logic          o_rsp_valid;
    logic [31:0]   o_rsp_rdata;
    logic          o_rsp_err;
    logic [AW-1:0] o_mem_addr;
    logic [31:0]   o_mem_wdata;
    logic [3:0]    o_mem_bmask;
    logic          o_mem_wren;
    logic [31:0]   i_mem_rdata;

    lsu_mem_ctrl #(.DEPTH(DEPTH)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_req_we(i_req_we), .i_req_size(i_req_size), .i_req_unsigned(i_req_unsigned),
        .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata),
        .o_rsp_valid(o_rsp_valid), .o_rsp_rdata(o_rsp_rdata), .o_rsp_err(o_rsp_err),
        .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .o_mem_bmask(o_mem_bmask),
        .o_mem_wren(o_mem_wren), .i_mem_rdata(i_mem_rdata)
    );

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    // Memory model: byte-masked write, registered read, clearable for the reset scenario.
    logic [31:0] mem [DEPTH/4];
    logic        mem_clr = 1'b0;
    always @(posedge i_clk) begin
        if (mem_clr) begin
            for (int i = 0; i < DEPTH/4; i++) mem[i] <= '0;
        end else if (o_mem_wren) begin
            for (int b = 0; b < 4; b++)
                if (o_mem_bmask[b]) mem[o_mem_addr[AW-1:2]][8*b +: 8] <= o_mem_wdata[8*b +: 8];
        end
        i_mem_rdata <= mem[o_mem_addr[AW-1:2]];
    end

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          acc_cyc;
    } rsp_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [3:0]    mask;
        logic [31:0]   data;
    } beat_t;

    rsp_t  rsp_q[$];
    beat_t beat_q[$];
    int    n_checks = 0;
    int    n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Output monitor: pops the scoreboard on every memory write beat and response pulse.
    always @(negedge i_clk) begin : monitor
        beat_t b;
        rsp_t  r;
        if (o_mem_wren) begin
            if (beat_q.size() == 0) begin
                check("unexpected_write", 64'(o_mem_addr), 64'hFFFF);
            end else begin
                b = beat_q.pop_front();
                check("mem_addr",  64'(o_mem_addr),  64'(b.addr));
                check("mem_bmask", 64'(o_mem_bmask), 64'(b.mask));
                check("mem_wdata", 64'(o_mem_wdata), 64'(b.data));
            end
        end
        if (o_rsp_valid) begin
            check("rsp_mem_quiet", {27'd0, o_mem_wren, o_mem_bmask, o_mem_wdata}, 64'd0);
            if (rsp_q.size() == 0) begin
                check("unexpected_rsp", 64'(o_rsp_rdata), 64'hFFFF_FFFF_FFFF);
            end else begin
                r = rsp_q.pop_front();
                check("rsp_rdata",   64'(o_rsp_rdata), 64'(r.rdata));
                check("rsp_err",     64'(o_rsp_err),   64'(r.err));
                check("rsp_latency", 64'(cyc - r.acc_cyc + 1), 64'(r.lat));
            end
        end
    end

    task automatic push_beat(input logic [AW-1:0] addr, input logic [3:0] mask, input logic [31:0] data);
        beat_t b;
        b.addr = addr; b.mask = mask; b.data = data;
        beat_q.push_back(b);
    endtask

    task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat,
                         input bit hold);
        rsp_t r;
        int   waited = 0;
        @(negedge i_clk);
        while (!o_req_ready && waited < 20) begin
            @(negedge i_clk);
            waited++;
        end
        if (!o_req_ready) check("ready_timeout", 64'(o_req_ready), 64'd1);
        i_req_valid = 1'b1; i_req_we = we; i_req_size = size;
        i_req_unsigned = uns; i_req_addr = addr; i_req_wdata = wdata;
        @(posedge i_clk);
        #1;
        r.rdata = exp_rdata; r.err = exp_err; r.lat = exp_lat; r.acc_cyc = cyc;
        rsp_q.push_back(r);
        check("ready_busy", 64'(o_req_ready), 64'd0);
        if (hold) begin
            // Valid stays high through a busy edge; it must be ignored.
            @(posedge i_clk);
            #1;
        end
        i_req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (rsp_q.size() != 0 && n < 30) begin
            @(posedge i_clk);
            #2;
            n++;
        end
        check("drain_timeout", 64'(rsp_q.size()), 64'd0);
        check("beats_left",    64'(beat_q.size()), 64'd0);
        rsp_q.delete();
        beat_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 i_rst_n = 1'b0;
        #2;
        check("rst_outputs", {o_rsp_valid, o_rsp_err, o_mem_wren, o_mem_bmask, 27'(o_mem_addr), o_mem_wdata}, 64'd0);
        check("rst_rdata", 64'(o_rsp_rdata), 64'd0);
        @(negedge i_clk) mem_clr = 1'b1;
        @(negedge i_clk) mem_clr = 1'b0;
        i_rst_n = 1'b1;
        @(negedge i_clk);
        check("ready_after_rst", 64'(o_req_ready), 64'd1);

        // Aligned word store / load; valid held through the busy cycle on the store.
        push_beat(5'd8, 4'b1111, 32'h1234_5678);
        issue(1'b1, 2'b10, 1'b0, 32'd8, 32'h1234_5678, 32'd0, 1'b0, 2, 1'b1);
        drain();
        issue(1'b0, 2'b10, 1'b0, 32'd8, 32'd0, 32'h1234_5678, 1'b0, 2, 1'b0);
        drain();

        // Byte store at offset 1; signed and unsigned byte loads.
        push_beat(5'd4, 4'b0010, 32'hBBCC_DD00);
        issue(1'b1, 2'b00, 1'b0, 32'd5, 32'hAABB_CCDD, 32'd0, 1'b0, 2, 1'b0);
        drain();
        issue(1'b0, 2'b00, 1'b0, 32'd5, 32'd0, 32'hFFFF_FFDD, 1'b0, 2, 1'b0);
        issue(1'b0, 2'b00, 1'b1, 32'd5, 32'd0, 32'h0000_00DD, 1'b0, 2, 1'b0);
        drain();

        // Word store crossing into the next word, then the matching split load.
        push_beat(5'd4, 4'b1100, 32'hBABE_0000);
        push_beat(5'd8, 4'b0011, 32'h0000_CAFE);
        issue(1'b1, 2'b10, 1'b0, 32'd6, 32'hCAFE_BABE, 32'd0, 1'b0, 3, 1'b0);
        drain();
        issue(1'b0, 2'b10, 1'b0, 32'd6, 32'd0, 32'hCAFE_BABE, 1'b0, 3, 1'b0);
        drain();

        // Half store at offset 3 splits one byte into each word.
        push_beat(5'd4, 4'b1000, 32'h0100_0000);
        push_beat(5'd8, 4'b0001, 32'h0000_0080);
        issue(1'b1, 2'b01, 1'b0, 32'd7, 32'h0000_8001, 32'd0, 1'b0, 3, 1'b0);
        drain();
        issue(1'b0, 2'b01, 1'b0, 32'd7, 32'd0, 32'hFFFF_8001, 1'b0, 3, 1'b0);
        issue(1'b0, 2'b01, 1'b1, 32'd7, 32'd0, 32'h0000_8001, 1'b0, 3, 1'b0);
        drain();

        // Range and size errors: no memory beat, one-cycle response.
        issue(1'b0, 2'b10, 1'b0, 32'd30, 32'd0, 32'd0, 1'b1, 1, 1'b0);
        issue(1'b0, 2'b11, 1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1, 1'b0);
        issue(1'b1, 2'b01, 1'b0, 32'd31, 32'hFFFF_FFFF, 32'd0, 1'b1, 1, 1'b0);
        issue(1'b0, 2'b10, 1'b0, 32'hFFFF_FFFC, 32'd0, 32'd0, 1'b1, 1, 1'b0);
        drain();
        // Last byte of memory is legal.
        push_beat(5'd28, 4'b1000, 32'h8500_0000);
        issue(1'b1, 2'b00, 1'b0, 32'd31, 32'h0000_0085, 32'd0, 1'b0, 2, 1'b0);
        drain();
        issue(1'b0, 2'b00, 1'b0, 32'd31, 32'd0, 32'hFFFF_FF85, 1'b0, 2, 1'b0);
        drain();

        // Reset during the second half of a crossing store: first half stays committed.
        @(negedge i_clk) mem_clr = 1'b1;
        @(negedge i_clk) mem_clr = 1'b0;
        push_beat(5'd4, 4'b1100, 32'hBABE_0000);
        issue(1'b1, 2'b10, 1'b0, 32'd6, 32'hCAFE_BABE, 32'd0, 1'b0, 3, 1'b0);
        rsp_q.delete();
        @(posedge i_clk);
        #1;
        check("acc2_wren_before_rst", 64'(o_mem_wren), 64'd1);
        i_rst_n = 1'b0;
        #1;
        check("rst_mid_clear", {o_rsp_valid, o_mem_wren, o_mem_bmask, 27'(o_mem_addr), o_mem_wdata}, 64'd0);
        repeat (2) @(posedge i_clk);
        check("rst_beats_left", 64'(beat_q.size()), 64'd0);
        #1 i_rst_n = 1'b1;
        @(negedge i_clk);
        check("ready_after_mid_rst", 64'(o_req_ready), 64'd1);
        issue(1'b0, 2'b10, 1'b0, 32'd4, 32'd0, 32'hBABE_0000, 1'b0, 2, 1'b0);
        issue(1'b0, 2'b10, 1'b0, 32'd8, 32'd0, 32'h0000_0000, 1'b0, 2, 1'b0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
